button_input_array: RTL and testbench

Parametrised, multi-channel successor to the two-button jump/duck input stage. Every channel provides:
- synchronisation of the raw pad input;
- polarity normalisation;
- counter-based debouncing;
- one-cycle press and release pulses;
- optional hold-to-repeat pulses.

The block sits between the board push-buttons and the game/control FSMs. Consumers can then react either to levels (duck held) or to single events (jump pressed) without local edge logic.

---
 rtl/btn_input_pkg.sv | 20 ++
 rtl/btn_channel.sv | 129 ++++++++++++
 rtl/button_input_array.sv | 59 +++++
 tb/tb_button_input_array.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/btn_input_pkg.sv
// Shared types and width helpers for the button input array.
// Repeat FSM encoding plus counter sizing used by every channel.
package btn_input_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold the values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: pad synchroniser, debounce counter, press/release
// pulses and an optional hold-to-repeat FSM.
module btn_channel
    import btn_input_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_press_nxt
);

    localparam int   CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int   RCNT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic POL    = (ACTIVE_LOW != 0);
    localparam logic RPT_EN = (REPEAT_DELAY > 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;
    logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
    rpt_state_e             rpt_q, rpt_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_btn ^ POL};

        // A new level is accepted only after DEBOUNCE_CYCLES disagreeing
        // samples in a row; any agreeing sample restarts the count.
        cnt_d   = cnt_q;
        state_d = state_q;
        if (sync_out == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d = ~state_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        press_d   = state_d & ~state_q;
        release_d = ~state_d & state_q;
    end

    // Repeat is keyed off the next debounced level so the release cycle
    // never carries a repeat pulse.
    always_comb begin
        rpt_d    = rpt_q;
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        if (!RPT_EN || !state_d) begin
            rpt_d  = RPT_IDLE;
            rcnt_d = '0;
        end else begin
            case (rpt_q)
                RPT_IDLE: begin
                    if (press_d) begin
                        rpt_d  = RPT_DELAY;
                        rcnt_d = RCNT_W'(1);
                    end
                end
                RPT_DELAY: begin
                    if (rcnt_q == RCNT_W'(REPEAT_DELAY)) begin
                        repeat_d = 1'b1;
                        rcnt_d   = RCNT_W'(1);
                        rpt_d    = RPT_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt_q == RCNT_W'(REPEAT_PERIOD)) begin
                        repeat_d = 1'b1;
                        rcnt_d   = RCNT_W'(1);
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    rpt_d  = RPT_IDLE;
                    rcnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            rcnt_q    <= '0;
            rpt_q     <= RPT_IDLE;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            rcnt_q    <= rcnt_d;
            rpt_q     <= rpt_d;
        end
    end

    assign o_state     = state_q;
    assign o_press     = press_q;
    assign o_release   = release_q;
    assign o_repeat    = repeat_q;
    assign o_press_nxt = press_d;

endmodule

// File: rtl/button_input_array.sv
// N_BTN independent debounced button channels with a shared any-press pulse
// registered in the same cycle as the per-channel press pulses.
module button_input_array
    import btn_input_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_state,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_repeat,
    output logic             o_any_press
);

    logic [N_BTN-1:0] press_nxt;
    logic             any_press_q, any_press_d;

    for (genvar k = 0; k < N_BTN; k++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_btn      (i_btn[k]),
            .o_state    (o_state[k]),
            .o_press    (o_press[k]),
            .o_release  (o_release[k]),
            .o_repeat   (o_repeat[k]),
            .o_press_nxt(press_nxt[k])
        );
    end

    always_comb begin
        any_press_d = |press_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign o_any_press = any_press_q;

endmodule

// File: tb/tb_button_input_array.sv
// Directed bench: clean press, repeat, channel independence, glitch
// rejection, reset mid-hold and an active-low instance.
module tb_button_input_array;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn = 2'b00;
    logic [1:0] al_btn = 2'b11;
    logic [1:0] st, pr, rl, rp;
    logic       any;
    logic [1:0] al_st, al_pr, al_rl, al_rp;
    logic       al_any;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    button_input_array #(
        .N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_btn(btn),
        .o_state(st), .o_press(pr), .o_release(rl), .o_repeat(rp),
        .o_any_press(any)
    );

    button_input_array #(
        .N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .i_btn(al_btn),
        .o_state(al_st), .o_press(al_pr), .o_release(al_rl), .o_repeat(al_rp),
        .o_any_press(al_any)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic chk_main(input string sc, input logic [1:0] e_st, input logic [1:0] e_pr,
                            input logic [1:0] e_rl, input logic [1:0] e_rp, input logic e_any);
        chk({sc, ".state"},   32'(st),  32'(e_st));
        chk({sc, ".press"},   32'(pr),  32'(e_pr));
        chk({sc, ".release"}, 32'(rl),  32'(e_rl));
        chk({sc, ".repeat"},  32'(rp),  32'(e_rp));
        chk({sc, ".any"},     32'(any), 32'(e_any));
    endtask

    task automatic chk_al(input string sc, input logic [1:0] e_st, input logic [1:0] e_pr,
                          input logic [1:0] e_rl, input logic [1:0] e_rp, input logic e_any);
        chk({sc, ".state"},   32'(al_st),  32'(e_st));
        chk({sc, ".press"},   32'(al_pr),  32'(e_pr));
        chk({sc, ".release"}, 32'(al_rl),  32'(e_rl));
        chk({sc, ".repeat"},  32'(al_rp),  32'(e_rp));
        chk({sc, ".any"},     32'(al_any), 32'(e_any));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Leaves the bench just after an edge with reset released: that is cycle 0.
    task automatic reset_dut();
        btn    = 2'b00;
        al_btn = 2'b11;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_main("rst", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        chk_al("rst_al", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        // Clean press + repeat on ch0, ch1 pressed two cycles later and released early.
        reset_dut();
        btn = 2'b01;
        while (cyc < 40) begin
            step();
            chk_main("A",
                     {1'(cyc >= 8 && cyc < 16), 1'(cyc >= 6 && cyc < 33)},
                     {1'(cyc == 8), 1'(cyc == 6)},
                     {1'(cyc == 16), 1'(cyc == 33)},
                     {1'b0, 1'(cyc inside {16, 21, 26, 31})},
                     1'(cyc == 6 || cyc == 8));
            if (cyc == 2)  btn[1] = 1'b1;
            if (cyc == 10) btn[1] = 1'b0;
            if (cyc == 27) btn[0] = 1'b0;
        end

        // Reset asserted during the hold, button kept high throughout.
        reset_dut();
        btn = 2'b01;
        while (cyc < 30) begin
            step();
            if (cyc <= 18)
                chk_main("B.pre", {1'b0, 1'(cyc >= 6)}, {1'b0, 1'(cyc == 6)}, 2'b00,
                         {1'b0, 1'(cyc == 16)}, 1'(cyc == 6));
            else if (cyc <= 20)
                chk_main("B.held", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            else
                chk_main("B.post", {1'b0, 1'(cyc >= 26)}, {1'b0, 1'(cyc == 26)}, 2'b00,
                         2'b00, 1'(cyc == 26));
            if (cyc == 18) begin
                rst_n = 1'b0;
                #1;
                chk_main("B.async", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            end
            if (cyc == 20) rst_n = 1'b1;
        end

        // Three-cycle glitch is rejected; a later clean press has normal latency.
        reset_dut();
        btn = 2'b01;
        while (cyc < 20) begin
            step();
            chk_main("C", {1'b0, 1'(cyc >= 18)}, {1'b0, 1'(cyc == 18)}, 2'b00, 2'b00,
                     1'(cyc == 18));
            if (cyc == 3)  btn = 2'b00;
            if (cyc == 12) btn = 2'b01;
        end

        // Active-low instance: press on 1->0, release on 0->1, no repeat in release cycle.
        reset_dut();
        al_btn = 2'b10;
        while (cyc < 20) begin
            step();
            chk_al("D", {1'b0, 1'(cyc >= 6 && cyc < 16)}, {1'b0, 1'(cyc == 6)},
                   {1'b0, 1'(cyc == 16)}, 2'b00, 1'(cyc == 6));
            if (cyc == 10) al_btn = 2'b11;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
